// File: rtl/piece_window_fetcher_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | piece_window_fetcher_pkg                                                   |
// | Board geometry, game state type and fetcher FSM encoding.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package piece_window_fetcher_pkg;

  localparam int BOARD_WIDTH  = 10;
  localparam int BOARD_HEIGHT = 20;

  localparam int c_req_x_w = $clog2(BOARD_WIDTH);
  localparam int c_req_y_w = $clog2(BOARD_HEIGHT);

  // screen[x][y]; y=0 is the bottom row
  typedef struct packed {
    logic [BOARD_WIDTH-1:0][BOARD_HEIGHT-1:0] screen;
  } game_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } win_fsm_t;

endpackage
`default_nettype wire

// File: rtl/piece_window_fetcher_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | piece_window_fetcher_if                                                    |
// | Request/window handshake bundle between game logic and the fetcher.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface piece_window_fetcher_if #(
  parameter int WIN = 6
);
  import piece_window_fetcher_pkg::*;

  game_state_t              state;
  logic                     req_valid;
  logic                     req_ready;
  logic [c_req_x_w-1:0]     req_x;
  logic [c_req_y_w-1:0]     req_y;
  logic                     win_valid;
  logic                     win_ready;
  logic [WIN-1:0][WIN-1:0]  window;

  modport master (
    output state, req_valid, req_x, req_y, win_ready,
    input  req_ready, win_valid, window
  );

  modport slave (
    input  state, req_valid, req_x, req_y, win_ready,
    output req_ready, win_valid, window
  );

endinterface
`default_nettype wire

// File: rtl/piece_window_fetcher_column_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_column_sampler                                                      |
// | One window column from the board at signed (wx, wy_base) with edge fills.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module window_column_sampler
  import piece_window_fetcher_pkg::*;
#(
  parameter int   WIN        = 6,
  parameter int   COORD_W    = 7,
  parameter logic WALL_FILL  = 1'b1,
  parameter logic FLOOR_FILL = 1'b0,
  parameter logic CEIL_FILL  = 1'b0
) (
  input  game_state_t                state,
  input  logic signed [COORD_W-1:0]  wx,
  input  logic signed [COORD_W-1:0]  wy_base,
  output logic        [WIN-1:0]      column
);

  localparam logic signed [COORD_W-1:0] c_board_w = COORD_W'(BOARD_WIDTH);
  localparam logic signed [COORD_W-1:0] c_board_h = COORD_W'(BOARD_HEIGHT);

  logic                 w_wall;
  logic [c_req_x_w-1:0] w_x_idx;

  // A wall column wins over floor/ceiling, so it is decided once per column
  assign w_wall  = wx[COORD_W-1] || (wx >= c_board_w);
  assign w_x_idx = wx[c_req_x_w-1:0];

  for (genvar ly = 0; ly < WIN; ly++) begin : g_row
    logic signed [COORD_W-1:0] w_wy;
    logic [c_req_y_w-1:0]      w_y_idx;

    assign w_wy    = wy_base + COORD_W'(ly);
    assign w_y_idx = w_wy[c_req_y_w-1:0];

    assign column[ly] = w_wall                 ? WALL_FILL  :
                        w_wy[COORD_W-1]        ? FLOOR_FILL :
                        (w_wy >= c_board_h)    ? CEIL_FILL  :
                        state.screen[w_x_idx][w_y_idx];
  end

endmodule
`default_nettype wire

// File: rtl/piece_window_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | piece_window_fetcher                                                       |
// | Builds a WIN x WIN board window around a piece, one column per cycle.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module piece_window_fetcher
  import piece_window_fetcher_pkg::*;
#(
  parameter int   WIN        = 6,
  parameter int   OFFSET_X   = 5,
  parameter int   OFFSET_Y   = 5,
  parameter logic WALL_FILL  = 1'b1,
  parameter logic FLOOR_FILL = 1'b0,
  parameter logic CEIL_FILL  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  piece_window_fetcher_if.slave   bus
);

  localparam int c_max_board = (BOARD_WIDTH > BOARD_HEIGHT) ? BOARD_WIDTH : BOARD_HEIGHT;
  localparam int c_max_off   = (OFFSET_X > OFFSET_Y) ? OFFSET_X : OFFSET_Y;
  localparam int c_coord_w   = $clog2(c_max_board + WIN + c_max_off) + 2;
  localparam int c_col_w     = $clog2(WIN);
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(WIN - 1);

  win_fsm_t                       r_state;
  win_fsm_t                       w_next_state;
  logic                           w_req_ready;
  logic                           w_win_valid;
  logic                           w_accept;
  logic [c_col_w-1:0]             r_col;
  logic signed [c_coord_w-1:0]    r_wx_base;
  logic signed [c_coord_w-1:0]    r_wy_base;
  logic signed [c_coord_w-1:0]    w_wx;
  logic [WIN-1:0]                 w_column;
  logic [WIN-1:0][WIN-1:0]        r_window;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_win_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_next_state = FETCH;
      end
      FETCH: begin
        if (r_col == c_last_col) w_next_state = DONE;
      end
      DONE: begin
        w_win_valid = 1'b1;
        if (bus.win_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_accept = w_req_ready && bus.req_valid;

  // Offsets are folded in at accept time so each column only adds r_col
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col     <= '0;
      r_wx_base <= '0;
      r_wy_base <= '0;
      r_window  <= '0;
    end else if (w_accept) begin
      r_col     <= '0;
      r_wx_base <= c_coord_w'(bus.req_x) - c_coord_w'(OFFSET_X);
      r_wy_base <= c_coord_w'(bus.req_y) - c_coord_w'(OFFSET_Y);
    end else if (r_state == FETCH) begin
      r_window[r_col] <= w_column;
      r_col           <= (r_col == c_last_col) ? '0 : r_col + c_col_w'(1);
    end
  end

  assign w_wx = r_wx_base + c_coord_w'(r_col);

  window_column_sampler #(
    .WIN        (WIN),
    .COORD_W    (c_coord_w),
    .WALL_FILL  (WALL_FILL),
    .FLOOR_FILL (FLOOR_FILL),
    .CEIL_FILL  (CEIL_FILL)
  ) u_sampler (
    .state   (bus.state),
    .wx      (w_wx),
    .wy_base (r_wy_base),
    .column  (w_column)
  );

  assign bus.req_ready = w_req_ready;
  assign bus.win_valid = w_win_valid;
  assign bus.window    = r_window;

endmodule
`default_nettype wire
